// File: rtl/dmem_bus_pkg.sv
// ============================================================================
// Module      : dmem_bus_pkg
// Description : Shared types and constants for the data-memory bus sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_WAIT_R = 3'd2,
        ST_DONE   = 3'd3,
        ST_FAULT  = 3'd4
    } dbc_state_t;

    localparam logic [2:0] SZ_B  = 3'd0;
    localparam logic [2:0] SZ_H  = 3'd1;
    localparam logic [2:0] SZ_W  = 3'd2;
    localparam logic [2:0] SZ_BU = 3'd4;
    localparam logic [2:0] SZ_HU = 3'd5;

    localparam logic [1:0] FC_NONE     = 2'd0;
    localparam logic [1:0] FC_MISALIGN = 2'd1;
    localparam logic [1:0] FC_ILLSIZE  = 2'd2;
    localparam logic [1:0] FC_TIMEOUT  = 2'd3;

    // Unsigned variants only exist for loads.
    function automatic logic size_is_legal(input logic [2:0] size, input logic we);
        case (size)
            SZ_B, SZ_H, SZ_W: size_is_legal = 1'b1;
            SZ_BU, SZ_HU:     size_is_legal = !we;
            default:          size_is_legal = 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_bus_ctrl_if.sv
// ============================================================================
// Module      : dmem_bus_ctrl_if
// Description : Valid/ready data-memory bus between sequencer and memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_bus_ctrl_if;
    logic        bus_valid_o;
    logic        bus_ready_i;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i;
    logic        bus_rvalid_i;

    modport master (
        output bus_valid_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
        input  bus_ready_i, bus_rdata_i, bus_rvalid_i
    );

    modport slave (
        input  bus_valid_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
        output bus_ready_i, bus_rdata_i, bus_rvalid_i
    );
endinterface

`default_nettype wire

// File: rtl/lsu_lane_align.sv
// ============================================================================
// Module      : lsu_lane_align
// Description : Byte-lane steering for stores, load extraction/extension and
//               access legality checks. Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_lane_align
    import dmem_bus_pkg::*;
(
    input  logic        i_st_we,
    input  logic [2:0]  i_st_size,
    input  logic [1:0]  i_st_offset,
    input  logic [31:0] i_st_wdata,
    input  logic [2:0]  i_ld_size,
    input  logic [1:0]  i_ld_offset,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load_data,
    output logic        o_misaligned,
    output logic        o_illegal
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_be    = 4'b0000;
        o_wdata = 32'd0;
        case (i_st_size)
            SZ_B, SZ_BU: begin
                o_be    = 4'b0001 << i_st_offset;
                o_wdata = {4{i_st_wdata[7:0]}};
            end
            SZ_H, SZ_HU: begin
                o_be    = 4'b0011 << i_st_offset;
                o_wdata = {2{i_st_wdata[15:0]}};
            end
            SZ_W: begin
                o_be    = 4'b1111;
                o_wdata = i_st_wdata;
            end
            default: begin
                o_be    = 4'b0000;
                o_wdata = 32'd0;
            end
        endcase
    end

    always_comb begin
        o_illegal    = !size_is_legal(i_st_size, i_st_we);
        o_misaligned = 1'b0;
        case (i_st_size)
            SZ_H, SZ_HU: o_misaligned = i_st_offset[0];
            SZ_W:        o_misaligned = (i_st_offset != 2'd0);
            default:     o_misaligned = 1'b0;
        endcase
    end

    always_comb begin
        w_byte = 8'h00;
        case (i_ld_offset)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_ld_offset[1] ? i_rdata[31:16] : i_rdata[15:0];

        case (i_ld_size)
            SZ_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
            SZ_BU:   o_load_data = {24'd0, w_byte};
            SZ_H:    o_load_data = {{16{w_half[15]}}, w_half};
            SZ_HU:   o_load_data = {16'd0, w_half};
            default: o_load_data = i_rdata;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/dmem_bus_ctrl.sv
// ============================================================================
// Module      : dmem_bus_ctrl
// Description : Turns single-cycle core load/store requests into one
//               valid/ready bus transaction each, stalling the core meanwhile.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_bus_ctrl
    import dmem_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_i,
    input  logic            we_i,
    input  logic [2:0]      size_i,
    input  logic [31:0]     addr_i,
    input  logic [31:0]     wdata_i,
    output logic [31:0]     rdata_o,
    output logic            stall_o,
    output logic            fault_o,
    output logic [1:0]      fault_cause_o,
    dmem_bus_ctrl_if.master bus
);

    localparam logic [15:0] c_timeout_last = 16'(TIMEOUT_CYCLES - 1);

    dbc_state_t  r_state;
    logic        r_we;
    logic [2:0]  r_size;
    logic [1:0]  r_offset;
    logic [31:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic [15:0] r_count;
    logic [1:0]  r_cause;

    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_load;
    logic        w_misaligned;
    logic        w_illegal;
    logic        w_timeout_hit;

    lsu_lane_align u_align (
        .i_st_we      (we_i),
        .i_st_size    (size_i),
        .i_st_offset  (addr_i[1:0]),
        .i_st_wdata   (wdata_i),
        .i_ld_size    (r_size),
        .i_ld_offset  (r_offset),
        .i_rdata      (bus.bus_rdata_i),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_load_data  (w_load),
        .o_misaligned (w_misaligned),
        .o_illegal    (w_illegal)
    );

    assign w_timeout_hit = (r_count == c_timeout_last);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= ST_IDLE;
            r_we     <= 1'b0;
            r_size   <= 3'd0;
            r_offset <= 2'd0;
            r_addr   <= 32'd0;
            r_be     <= 4'd0;
            r_wdata  <= 32'd0;
            r_rdata  <= 32'd0;
            r_count  <= 16'd0;
            r_cause  <= FC_NONE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_i) begin
                        if (w_illegal) begin
                            r_cause <= FC_ILLSIZE;
                            r_state <= ST_FAULT;
                        end else if (w_misaligned) begin
                            r_cause <= FC_MISALIGN;
                            r_state <= ST_FAULT;
                        end else begin
                            r_we     <= we_i;
                            r_size   <= size_i;
                            r_offset <= addr_i[1:0];
                            r_addr   <= {addr_i[31:2], 2'b00};
                            r_be     <= w_be;
                            r_wdata  <= w_wdata;
                            r_rdata  <= 32'd0;
                            r_count  <= 16'd0;
                            r_state  <= ST_REQ;
                        end
                    end
                end
                // A load accepted on the last allowed cycle still times out:
                // only a finished store or returned read data counts as done.
                ST_REQ: begin
                    r_count <= r_count + 16'd1;
                    if (bus.bus_ready_i && r_we) begin
                        r_state <= ST_DONE;
                    end else if (w_timeout_hit) begin
                        r_cause <= FC_TIMEOUT;
                        r_state <= ST_FAULT;
                    end else if (bus.bus_ready_i) begin
                        r_state <= ST_WAIT_R;
                    end
                end
                ST_WAIT_R: begin
                    r_count <= r_count + 16'd1;
                    if (bus.bus_rvalid_i) begin
                        r_rdata <= w_load;
                        r_state <= ST_DONE;
                    end else if (w_timeout_hit) begin
                        r_cause <= FC_TIMEOUT;
                        r_state <= ST_FAULT;
                    end
                end
                ST_DONE:  r_state <= ST_IDLE;
                ST_FAULT: r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    assign stall_o = !rst_i && (((r_state == ST_IDLE) && req_i) ||
                                (r_state == ST_REQ) || (r_state == ST_WAIT_R));
    assign rdata_o       = (r_state == ST_DONE) ? r_rdata : 32'd0;
    assign fault_o       = (r_state == ST_FAULT);
    assign fault_cause_o = (r_state == ST_FAULT) ? r_cause : FC_NONE;

    assign bus.bus_valid_o = (r_state == ST_REQ);
    assign bus.bus_we_o    = r_we;
    assign bus.bus_addr_o  = r_addr;
    assign bus.bus_be_o    = r_be;
    assign bus.bus_wdata_o = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_dmem_bus_ctrl.sv
// ============================================================================
// Module      : tb_dmem_bus_ctrl
// Description : Randomised scoreboard bench for dmem_bus_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_bus_ctrl;

    localparam int TB_T = 8;

    typedef struct {
        bit          fault;
        logic [1:0]  cause;
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req_i, we_i;
    logic [2:0]  size_i;
    logic [31:0] addr_i, wdata_i, rdata_o;
    logic        stall_o, fault_o;
    logic [1:0]  fault_cause_o;

    logic        req2;
    logic [31:0] rdata2;
    logic        stall2, fault2;
    logic [1:0]  cause2;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t exp_q[$];
    bus_t bus_q[$];

    dmem_bus_ctrl_if bus();
    dmem_bus_ctrl_if bus2();

    dmem_bus_ctrl #(.TIMEOUT_CYCLES(TB_T)) dut (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .size_i(size_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o), .stall_o(stall_o),
        .fault_o(fault_o), .fault_cause_o(fault_cause_o), .bus(bus.master)
    );

    dmem_bus_ctrl #(.TIMEOUT_CYCLES(4)) dut_t4 (
        .clk_i(clk), .rst_i(rst_i), .req_i(req2), .we_i(1'b1), .size_i(3'd2),
        .addr_i(32'h0000_0100), .wdata_i(32'h1234_5678), .rdata_o(rdata2),
        .stall_o(stall2), .fault_o(fault2), .fault_cause_o(cause2), .bus(bus2.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: derives the outcome from the access rules directly.
    function automatic void model(input bit we, input logic [2:0] sz, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [31:0] rdata,
                                  input int d_r, input int d_v,
                                  output exp_t e, output bus_t b, output bit b_valid);
        int n, off, need;
        logic [63:0] mask, v;
        bit legal;
        e.fault = 0; e.cause = 2'd0; e.rdata = 32'd0; e.lat = 2;
        b.we = we; b.addr = {addr[31:2], 2'b00}; b.be = 4'd0; b.wdata = 32'd0;
        b_valid = 0;
        legal = (sz <= 3'd2) || ((sz == 3'd4 || sz == 3'd5) && !we);
        if (!legal) begin
            e.fault = 1; e.cause = 2'd2;
            return;
        end
        n   = 1 << sz[1:0];
        off = int'(addr[1:0]);
        if (off % n != 0) begin
            e.fault = 1; e.cause = 2'd1;
            return;
        end
        b.be = 4'(((1 << n) - 1) << off);
        for (int i = 0; i < 4; i++)
            b.wdata[8*i +: 8] = 8'(wdata >> (8 * (i % n)));
        b_valid = (d_r < TB_T);
        need = (d_r + 1) + (we ? 0 : (d_v + 1));
        if (need > TB_T) begin
            e.fault = 1; e.cause = 2'd3; e.lat = TB_T + 2;
            return;
        end
        e.lat = need + 2;
        if (!we) begin
            mask = (64'd1 << (8 * n)) - 64'd1;
            v = ({32'd0, rdata} >> (8 * off)) & mask;
            if (!sz[2] && ((v >> (8 * n - 1)) & 64'd1) != 64'd0)
                v = v | ~mask;
            e.rdata = v[31:0];
        end
    endfunction

    // Monitor: bus requests and completions are checked against the queues.
    initial begin : monitor
        bit          prev_stall = 0;
        bit          holding = 0;
        int          stall_cnt = 0;
        bus_t        snap, eb;
        exp_t        ee;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                prev_stall = 0; holding = 0; stall_cnt = 0;
            end else begin
                if (bus.bus_valid_o) begin
                    if (holding) begin
                        chk("bus_hold_addr", bus.bus_addr_o, snap.addr);
                        chk("bus_hold_be", {28'd0, bus.bus_be_o}, {28'd0, snap.be});
                        chk("bus_hold_wdata", bus.bus_wdata_o, snap.wdata);
                    end
                    snap.addr = bus.bus_addr_o; snap.be = bus.bus_be_o;
                    snap.wdata = bus.bus_wdata_o;
                    holding = !bus.bus_ready_i;
                    if (bus.bus_ready_i) begin
                        if (bus_q.size() == 0) begin
                            chk("bus_unexpected_req", 32'd1, 32'd0);
                        end else begin
                            eb = bus_q.pop_front();
                            chk("bus_we", {31'd0, bus.bus_we_o}, {31'd0, eb.we});
                            chk("bus_addr", bus.bus_addr_o, eb.addr);
                            chk("bus_be", {28'd0, bus.bus_be_o}, {28'd0, eb.be});
                            if (eb.we) chk("bus_wdata", bus.bus_wdata_o, eb.wdata);
                        end
                    end
                end else begin
                    holding = 0;
                end
                if (stall_o) begin
                    stall_cnt++;
                end else if (prev_stall) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_completion", 32'd1, 32'd0);
                    end else begin
                        ee = exp_q.pop_front();
                        chk("fault", {31'd0, fault_o}, {31'd0, ee.fault});
                        chk("fault_cause", {30'd0, fault_cause_o}, {30'd0, ee.cause});
                        chk("rdata", rdata_o, ee.rdata);
                        chk("latency", stall_cnt + 1, ee.lat);
                    end
                    stall_cnt = 0;
                end else if (fault_o) begin
                    chk("spurious_fault", {31'd0, fault_o}, 32'd0);
                end
                prev_stall = stall_o;
            end
        end
    end

    task automatic idle_gap(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            bus.bus_rvalid_i = ($urandom_range(0, 2) == 0);
            bus.bus_rdata_i  = $urandom;
        end
        bus.bus_rvalid_i = 1'b0;
    endtask

    // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the next IDLE cycle.
    task automatic run_txn(input bit we, input logic [2:0] sz, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int d_r, input int d_v);
        exp_t e; bus_t b; bit bv;
        int vcnt = 0, wcnt = 0;
        bit shaken = 0, done = 0;
        model(we, sz, addr, wdata, rdata, d_r, d_v, e, b, bv);
        exp_q.push_back(e);
        if (bv) bus_q.push_back(b);
        req_i = 1'b1; we_i = we; size_i = sz; addr_i = addr; wdata_i = wdata;
        bus.bus_ready_i = 1'b0; bus.bus_rvalid_i = 1'b0;
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            @(posedge clk); #1;
            bus.bus_ready_i  = 1'b0;
            bus.bus_rvalid_i = 1'b0;
            bus.bus_rdata_i  = $urandom;
            if (!stall_o) begin
                done = 1;
            end else if (bus.bus_valid_o) begin
                if (vcnt == d_r) begin
                    bus.bus_ready_i = 1'b1;
                    shaken = 1;
                end else begin
                    bus.bus_rvalid_i = ($urandom_range(0, 3) == 0);
                end
                vcnt++;
            end else if (shaken) begin
                if (wcnt == d_v) begin
                    bus.bus_rvalid_i = 1'b1;
                    bus.bus_rdata_i  = rdata;
                end
                wcnt++;
            end
        end
        if (!done) chk("txn_cycle_budget", 32'd0, 32'd1);
        @(posedge clk); #1;
        req_i = 1'b0; bus.bus_ready_i = 1'b0; bus.bus_rvalid_i = 1'b0;
    endtask

    task automatic reset_mid_read();
        exp_t e; bus_t b; bit bv;
        model(1'b0, 3'd2, 32'h0000_0500, 32'd0, 32'd0, 0, 0, e, b, bv);
        bus_q.push_back(b);
        req_i = 1'b1; we_i = 1'b0; size_i = 3'd2; addr_i = 32'h0000_0500;
        @(posedge clk); #1;
        bus.bus_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.bus_ready_i = 1'b0;
        chk("wait_r_stalled", {31'd0, stall_o}, 32'd1);
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0; req_i = 1'b0;
        @(negedge clk);
        chk("rst_mid_stall", {31'd0, stall_o}, 32'd0);
        chk("rst_mid_valid", {31'd0, bus.bus_valid_o}, 32'd0);
        chk("rst_mid_addr", bus.bus_addr_o, 32'd0);
        chk("rst_mid_be", {28'd0, bus.bus_be_o}, 32'd0);
        @(posedge clk); #1;
        bus.bus_rvalid_i = 1'b1; bus.bus_rdata_i = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("late_rvalid_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk); #1;
        bus.bus_rvalid_i = 1'b0;
        @(negedge clk);
        chk("late_rvalid_rdata", rdata_o, 32'd0);
        chk("late_rvalid_fault", {31'd0, fault_o}, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic timeout_t4();
        int vcount = 0;
        bit seen = 0;
        req2 = 1'b1;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            if (bus2.bus_valid_o) vcount++;
            if (fault2) seen = 1;
        end
        chk("t4_fault_seen", {31'd0, seen}, 32'd1);
        chk("t4_valid_cycles", vcount, 4);
        chk("t4_cause", {30'd0, cause2}, 32'd3);
        @(posedge clk); #1;
        req2 = 1'b0;
        @(negedge clk);
        chk("t4_idle_valid", {31'd0, bus2.bus_valid_o}, 32'd0);
        chk("t4_idle_stall", {31'd0, stall2}, 32'd0);
        chk("t4_idle_fault", {31'd0, fault2}, 32'd0);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [2:0] sz;
        logic [31:0] a;
        bit we;
        rst_i = 1'b1; req_i = 1'b1; we_i = 1'b0; size_i = 3'd2;
        addr_i = 32'd0; wdata_i = 32'd0; req2 = 1'b0;
        bus.bus_ready_i = 1'b0; bus.bus_rvalid_i = 1'b0; bus.bus_rdata_i = 32'd0;
        bus2.bus_ready_i = 1'b0; bus2.bus_rvalid_i = 1'b0; bus2.bus_rdata_i = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_stall_forced", {31'd0, stall_o}, 32'd0);
        @(posedge clk); #1;
        rst_i = 1'b0; req_i = 1'b0;
        @(negedge clk);
        chk("reset_stall", {31'd0, stall_o}, 32'd0);
        chk("reset_fault", {30'd0, fault_o, 1'b0} | {30'd0, fault_cause_o}, 32'd0);
        chk("reset_rdata", rdata_o, 32'd0);
        chk("reset_valid", {31'd0, bus.bus_valid_o}, 32'd0);
        chk("reset_addr", bus.bus_addr_o, 32'd0);
        chk("reset_wdata", bus.bus_wdata_o, 32'd0);
        @(posedge clk); #1;

        run_txn(1'b1, 3'd0, 32'h0000_1003, 32'h0000_00A5, 32'd0, 0, 0);
        run_txn(1'b0, 3'd0, 32'h0000_2002, 32'd0, 32'h0080_FF00, 0, 1);
        run_txn(1'b0, 3'd4, 32'h0000_2002, 32'd0, 32'h0080_FF00, 0, 1);
        run_txn(1'b0, 3'd2, 32'h0000_3002, 32'd0, 32'd0, 0, 0);
        run_txn(1'b1, 3'd4, 32'h0000_3000, 32'h1111_2222, 32'd0, 0, 0);
        run_txn(1'b0, 3'd1, 32'h0000_4000, 32'd0, 32'h1234_8001, 3, 0);
        run_txn(1'b1, 3'd2, 32'h0000_5000, 32'hCAFE_F00D, 32'd0, 20, 0);
        run_txn(1'b0, 3'd5, 32'h0000_6001, 32'd0, 32'd0, 0, 0);
        run_txn(1'b1, 3'd1, 32'h0000_6002, 32'h0000_BEEF, 32'd0, 1, 0);

        for (int t = 0; t < 150; t++) begin
            sz = 3'($urandom_range(0, 7));
            we = 1'($urandom_range(0, 1));
            a  = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            idle_gap($urandom_range(0, 2));
            run_txn(we, sz, a, $urandom, $urandom, $urandom_range(0, 5), $urandom_range(0, 5));
        end

        reset_mid_read();
        run_txn(1'b0, 3'd1, 32'h0000_7002, 32'd0, 32'h8001_0000, 0, 0);
        timeout_t4();

        repeat (4) @(posedge clk);
        chk("exp_queue_drained", exp_q.size(), 0);
        chk("bus_queue_drained", bus_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
